sram_mem_responder: RTL and testbench
=====================================

// Module: sram_mem_responder
// PURPOSE
//  Memory-stage responder for the pipeline's data-memory requests (mem_read / mem_write from decode, carried down the pipe).
//  Turns one 32-bit word request into two 16-bit accesses on an external asynchronous SRAM, inserting wait states.
//  Asserts ready for exactly one cycle on completion. The pipeline holds the stall (freeze = (mem_read|mem_write) & ~ready).
// PARAMETERS
//  BASE_ADDR    1024  byte address that maps to SRAM word 0
//  WAIT_CYCLES  3     cycles per 16-bit half-access (>=2)
//  SRAM_AW      18    SRAM address width
// PORTS
//  clk           in   1        clock, all logic on rising edge
//  rst           in   1        synchronous, active-high reset
//  mem_read      in   1        read request; held stable until ready
//  mem_write     in   1        write request; held stable until ready
//  address       in   32       byte address (word aligned, >= BASE_ADDR)
//  write_data    in   32       store data
//  read_data     out  32       load data, valid while ready=1 on a read
//  ready         out  1        one-cycle completion pulse
//  sram_addr     out  SRAM_AW  SRAM halfword address
//  sram_dq_out   out  16       SRAM write data
//  sram_dq_oe    out  1        drive sram_dq_out onto the bus
//  sram_dq_in    in   16       SRAM read data
//  sram_we_n     out  1        SRAM write enable, active low
// BEHAVIOUR
//  - Reset: state=IDLE, ready=0, read_data=0, sram_addr=0, sram_dq_out=0, sram_dq_oe=0, sram_we_n=1, wait counter=0.
//    Reset mid-access aborts immediately. No further SRAM strobes.
//  - Address mapping: off = address - BASE_ADDR (32-bit wrap). Low half at sram_addr = {off[SRAM_AW:2],1'b0}; high half at {off[SRAM_AW:2],1'b1}.
//  - FSM: IDLE -> LOW -> HIGH -> DONE -> IDLE.
//    IDLE: on (mem_read|mem_write), latch address, write_data and op, clear counter, go to LOW.
//          If both requests are high, the write wins.
//    LOW/HIGH: each lasts WAIT_CYCLES cycles. sram_addr is held for the whole phase.
//      Write: sram_dq_oe=1 for the whole phase. sram_dq_out = data[15:0] in LOW, data[31:16] in HIGH.
//             sram_we_n=0 for the first WAIT_CYCLES-1 cycles and 1 on the last cycle (data hold).
//      Read: sram_dq_oe=0, sram_we_n=1. On the last phase cycle, sram_dq_in is captured into read_data[15:0] (LOW) or read_data[31:16] (HIGH).
//    DONE: ready=1 for exactly one cycle. read_data stays stable until the next read completes. Then go to IDLE.
//  - Latency: request first seen in IDLE at cycle T -> ready=1 at cycle T+1+2*WAIT_CYCLES (T+7 at default).
//  - Because the pipeline advances on the ready cycle, a request seen in IDLE the cycle after DONE is a new one, accepted with no bubble.
//  - Request inputs are ignored outside IDLE; the latched copy is used.
//  - ready is never asserted without a prior request. Idle cycles keep the SRAM outputs at their reset values.
// CONFIGURATION
//  SRAM_LAST_READ_EN defined:
//    - Registers last_addr, last_data and last_valid (last_valid=0 on reset).
//    - Read in IDLE with last_valid && address==last_addr goes straight to DONE. No SRAM access; ready at T+1; read_data=last_data.
//    - Every completed SRAM read loads last_addr/last_data and sets last_valid.
//    - Any write accepted in IDLE clears last_valid.
//  SRAM_LAST_READ_EN undefined: none of this logic exists. Every read takes the full latency.
// TESTING
//  1 Write 0xDEADBEEF @1024, W=3: sram_addr 0 with dq 0xBEEF, then 1 with dq 0xDEAD; we_n low 2 of 3 cycles per phase; ready at T+7.
//  2 Read @1028 with SRAM model [2]=0x5678, [3]=0x1234: read_data=0x12345678 with ready at T+7; sram_we_n stays 1.
//  3 No requests for 20 cycles after reset: ready=0, sram_we_n=1, sram_dq_oe=0 throughout.
//  4 rst=1 during HIGH of a write: next cycle IDLE, we_n=1, oe=0. SRAM word high half not written; low half written.
//  5 Back-to-back write then read of the same address: second op accepted the cycle after ready; returns the written value.
//  6 [SRAM_LAST_READ_EN] Read 1024 twice: second ready at T+1, no SRAM strobe. Write 1024, then read: full T+7 latency.

Source files
------------

// File: rtl/sram_mem_responder.sv
// rtl/sram_mem_responder.sv - 32-bit memory-stage responder over a 16-bit asynchronous SRAM
// Optional feature macro: SRAM_LAST_READ_EN (one-entry last-read bypass).
module sram_mem_responder #(
    parameter int unsigned BASE_ADDR   = 1024,
    parameter int unsigned WAIT_CYCLES = 3,
    parameter int unsigned SRAM_AW     = 18
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mem_read,
    input  logic               mem_write,
    input  logic [31:0]        address,
    input  logic [31:0]        write_data,
    output logic [31:0]        read_data,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [15:0]        sram_dq_out,
    output logic               sram_dq_oe,
    input  logic [15:0]        sram_dq_in,
    output logic               sram_we_n
);
    localparam int CW = $clog2(WAIT_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_HOLD = CW'(WAIT_CYCLES - 2);

    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic               is_write;
    logic [SRAM_AW-2:0] word_q;
    logic [15:0]        wdata_hi;
    logic [15:0]        rd_low;
    logic [SRAM_AW-2:0] req_word;

    assign req_word = (SRAM_AW-1)'((address - BASE_ADDR) >> 2);

`ifdef SRAM_LAST_READ_EN
    logic [31:0] addr_q;
    logic [31:0] last_addr;
    logic [31:0] last_data;
    logic        last_valid;
    logic        hit;

    assign hit = mem_read && !mem_write && last_valid && (address == last_addr);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            is_write    <= 1'b0;
            word_q      <= '0;
            wdata_hi    <= '0;
            rd_low      <= '0;
            read_data   <= '0;
            ready       <= 1'b0;
            sram_addr   <= '0;
            sram_dq_out <= '0;
            sram_dq_oe  <= 1'b0;
            sram_we_n   <= 1'b1;
`ifdef SRAM_LAST_READ_EN
            addr_q      <= '0;
            last_addr   <= '0;
            last_data   <= '0;
            last_valid  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (mem_read || mem_write) begin
                        is_write <= mem_write;
                        word_q   <= req_word;
                        wdata_hi <= write_data[31:16];
`ifdef SRAM_LAST_READ_EN
                        addr_q <= address;
                        if (mem_write) last_valid <= 1'b0;
                        if (hit) begin
                            state     <= DONE;
                            ready     <= 1'b1;
                            read_data <= last_data;
                        end else
`endif
                        begin
                            state       <= LOW;
                            sram_addr   <= {req_word, 1'b0};
                            sram_dq_out <= mem_write ? write_data[15:0] : 16'h0000;
                            sram_dq_oe  <= mem_write;
                            sram_we_n   <= !mem_write;
                        end
                    end
                end
                LOW: begin
                    if (cnt == CNT_LAST) begin
                        cnt         <= '0;
                        state       <= HIGH;
                        rd_low      <= sram_dq_in;
                        sram_addr   <= {word_q, 1'b1};
                        sram_dq_out <= is_write ? wdata_hi : 16'h0000;
                        sram_we_n   <= !is_write;
                    end else begin
                        cnt <= cnt + 1'b1;
                        // Release WE one cycle early so data is held past the strobe edge
                        if (cnt == CNT_HOLD) sram_we_n <= 1'b1;
                    end
                end
                HIGH: begin
                    if (cnt == CNT_LAST) begin
                        cnt         <= '0;
                        state       <= DONE;
                        ready       <= 1'b1;
                        sram_addr   <= '0;
                        sram_dq_out <= '0;
                        sram_dq_oe  <= 1'b0;
                        sram_we_n   <= 1'b1;
                        if (!is_write) begin
                            read_data <= {sram_dq_in, rd_low};
`ifdef SRAM_LAST_READ_EN
                            last_addr  <= addr_q;
                            last_data  <= {sram_dq_in, rd_low};
                            last_valid <= 1'b1;
`endif
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (cnt == CNT_HOLD) sram_we_n <= 1'b1;
                    end
                end
                DONE: begin
                    ready <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sram_mem_responder.sv
// tb/tb_sram_mem_responder.sv - scoreboard bench for sram_mem_responder
// Honors SRAM_LAST_READ_EN to predict bypass latency.
module tb_sram_mem_responder;
    localparam int W = 3;
`ifdef SRAM_LAST_READ_EN
    localparam bit LAST_EN = 1'b1;
`else
    localparam bit LAST_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [31:0] address = 32'h0;
    logic [31:0] write_data = 32'h0;
    logic [31:0] read_data;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic        sram_dq_oe;
    logic [15:0] sram_dq_in;
    logic        sram_we_n;

    int checks = 0;
    int fails = 0;
    int cyc = 0;

    logic [15:0] mem [0:255];
    logic        pend;
    logic [7:0]  pend_a;
    logic [15:0] pend_d;

    typedef struct {
        int          exp_cyc;
        logic [31:0] exp_data;
    } resp_t;
    resp_t sb[$];
    resp_t mon_e;

    logic [31:0] tb_last_rd = 32'h0;
    bit          tb_lv = 1'b0;
    logic [31:0] tb_la = 32'h0;
    logic [31:0] tb_ld = 32'h0;

    sram_mem_responder dut (
        .clk         (clk),
        .rst         (rst),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .address     (address),
        .write_data  (write_data),
        .read_data   (read_data),
        .ready       (ready),
        .sram_addr   (sram_addr),
        .sram_dq_out (sram_dq_out),
        .sram_dq_oe  (sram_dq_oe),
        .sram_dq_in  (sram_dq_in),
        .sram_we_n   (sram_we_n)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign sram_dq_in = mem[sram_addr[7:0]];

    // SRAM model: a write commits when WE rises while the data bus is still driven
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[2] = 16'h5678;
        mem[3] = 16'h1234;
        pend = 1'b0;
        forever begin
            @(negedge clk);
            if (sram_we_n === 1'b0) begin
                pend   = 1'b1;
                pend_a = sram_addr[7:0];
                pend_d = sram_dq_out;
            end else begin
                if (pend && sram_dq_oe === 1'b1) mem[pend_a] = pend_d;
                pend = 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (ready === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_ready", {63'h0, ready}, 64'h0);
            end else begin
                mon_e = sb.pop_front();
                check("ready_cycle", cyc, mon_e.exp_cyc);
                check("read_data", read_data, mon_e.exp_data);
            end
        end
    end

    task automatic issue(input bit rd, input bit wr, input logic [31:0] a,
                         input logic [31:0] d, input logic [31:0] exp_rd, input string tag);
        int          c;
        int          k;
        bit          hit;
        logic [31:0] exp_out;
        logic [17:0] h;
        logic [35:0] exp_s;
        @(posedge clk); #1;
        mem_read = rd;
        mem_write = wr;
        address = a;
        write_data = d;
        c = cyc;
        hit = LAST_EN && !wr && tb_lv && (a == tb_la);
        if (wr) begin
            exp_out = tb_last_rd;
            tb_lv = 1'b0;
        end else begin
            exp_out = exp_rd;
            tb_last_rd = exp_rd;
            if (!hit) begin
                tb_lv = 1'b1;
                tb_la = a;
                tb_ld = exp_rd;
            end
        end
        sb.push_back('{c + (hit ? 1 : 1 + 2 * W), exp_out});
        h = 18'(((a - 32'd1024) >> 2) << 1);
        k = 0;
        do begin
            @(posedge clk); #1;
            k++;
            if (hit || k > 2 * W) begin
                exp_s = {18'h0, 16'h0, 1'b0, 1'b1};
            end else begin
                exp_s[35:18] = h | 18'(k > W);
                exp_s[17:2]  = wr ? ((k <= W) ? d[15:0] : d[31:16]) : 16'h0000;
                exp_s[1]     = wr;
                exp_s[0]     = !wr || (((k - 1) % W) == W - 1);
            end
            check({tag, "_strobes"}, {28'h0, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n}, {28'h0, exp_s});
        end while (ready !== 1'b1 && k < 40);
        if (ready !== 1'b1) check({tag, "_timeout"}, {63'h0, ready}, 64'h1);
    endtask

    task automatic release_req();
        @(posedge clk); #1;
        mem_read = 1'b0;
        mem_write = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", {63'h0, ready}, 64'h0);
        check("rst_read_data", read_data, 64'h0);
        check("rst_strobes", {sram_addr, sram_dq_out, sram_dq_oe, sram_we_n}, {18'h0, 16'h0, 1'b0, 1'b1});
        rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            check("idle_quiet", {ready, sram_we_n, sram_dq_oe}, 3'b010);
        end

        issue(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 32'h0, "wr1024");
        release_req();
        check("mem0_low", mem[0], 16'hBEEF);
        check("mem1_high", mem[1], 16'hDEAD);

        issue(1'b1, 1'b0, 32'd1028, 32'h0, 32'h12345678, "rd1028");
        release_req();

        // Abort a write during the first cycle of its high phase
        @(posedge clk); #1;
        mem_write = 1'b1;
        address = 32'd1032;
        write_data = 32'hAAAA5555;
        repeat (4) @(posedge clk);
        #1;
        check("abort_pre", {sram_addr, sram_dq_oe, sram_we_n}, {18'd5, 1'b1, 1'b0});
        rst = 1'b1;
        mem_write = 1'b0;
        @(posedge clk); #1;
        check("abort_post", {sram_addr, sram_dq_oe, sram_we_n, ready}, {18'd0, 1'b0, 1'b1, 1'b0});
        check("abort_read_data", read_data, 64'h0);
        rst = 1'b0;
        tb_lv = 1'b0;
        tb_last_rd = 32'h0;
        repeat (10) @(posedge clk);
        #1;
        check("abort_mem_low", mem[4], 16'h5555);
        check("abort_mem_high", mem[5], 16'h0000);

        issue(1'b0, 1'b1, 32'd1040, 32'hCAFEF00D, 32'h0, "wr1040");
        issue(1'b1, 1'b0, 32'd1040, 32'h0, 32'hCAFEF00D, "rd1040");
        issue(1'b1, 1'b1, 32'd1044, 32'h0BAD0BAD, 32'h0, "both1044");
        issue(1'b1, 1'b0, 32'd1044, 32'h0, 32'h0BAD0BAD, "rd1044");

        issue(1'b1, 1'b0, 32'd1024, 32'h0, 32'hDEADBEEF, "rd1024a");
        issue(1'b1, 1'b0, 32'd1024, 32'h0, 32'hDEADBEEF, "rd1024b");
        issue(1'b0, 1'b1, 32'd1024, 32'h11223344, 32'h0, "wr1024b");
        issue(1'b1, 1'b0, 32'd1024, 32'h0, 32'h11223344, "rd1024c");
        release_req();

        repeat (5) @(posedge clk);
        #1;
        check("sb_drained", sb.size(), 64'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
